// File: rtl/mem_wb_elastic_pipe.sv
// mem_wb_elastic_pipe
//   MEM->WB pipeline register built from STAGES cascaded elastic slots. Each
//   slot is a main register plus a skid register, so the WB side can apply
//   back-pressure without losing MEM results and without a combinational
//   path from out_ready to in_ready. Also provides global freeze,
//   synchronous flush and the write-back value mux.
//
//   Parameters: BIT_NUMBER (data width), DEST_BITS (register index width),
//               STAGES (>=1, number of slots; sets zero-stall latency).
//
//   Ports:
//     clk, rst (synchronous, active-low), freeze, flush
//     in_valid / in_ready, WB_en_in, Mem_R_en_in, ALU_result_in,
//       Mem_read_value_in, Dest_in              -- MEM stage side
//     out_valid / out_ready, WB_en, Mem_R_en, ALU_result, Mem_read_value,
//       Dest, WB_value                          -- WB stage side (head entry)
//
//   Optional feature macro MEM_WB_PERF_CNT_EN: adds saturating 16-bit
//   stall_cnt and flush_cnt outputs. Datapath is identical either way.
module mem_wb_elastic_pipe #(
  parameter int BIT_NUMBER = 32,
  parameter int DEST_BITS  = 4,
  parameter int STAGES     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  WB_en_in,
  input  logic                  Mem_R_en_in,
  input  logic [BIT_NUMBER-1:0] ALU_result_in,
  input  logic [BIT_NUMBER-1:0] Mem_read_value_in,
  input  logic [DEST_BITS-1:0]  Dest_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  WB_en,
  output logic                  Mem_R_en,
  output logic [BIT_NUMBER-1:0] ALU_result,
  output logic [BIT_NUMBER-1:0] Mem_read_value,
  output logic [DEST_BITS-1:0]  Dest,
  output logic [BIT_NUMBER-1:0] WB_value
`ifdef MEM_WB_PERF_CNT_EN
  ,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           flush_cnt
`endif
);

  localparam int W = 2 + 2 * BIT_NUMBER + DEST_BITS;

  // Payload packing: {WB_en, Mem_R_en, ALU_result, Mem_read_value, Dest}
  logic [W-1:0]      in_data;
  logic [W-1:0]      head_data;
  logic              head_wb_en;

  logic [STAGES-1:0] main_valid;
  logic [STAGES-1:0] skid_valid;
  logic [W-1:0]      main_data [STAGES];
  logic [STAGES-1:0] up_valid;
  logic [STAGES-1:0] down_ready;
  logic [W-1:0]      up_data [STAGES];

  assign in_data = {WB_en_in, Mem_R_en_in, ALU_result_in, Mem_read_value_in, Dest_in};

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_slot
      logic         main_valid_reg;
      logic         skid_valid_reg;
      logic [W-1:0] main_data_reg;
      logic [W-1:0] skid_data_reg;
      logic         accept;
      logic         drain;

      // Upstream of slot 0 is the MEM stage; otherwise the previous slot's main reg.
      if (gi == 0) begin : g_up_first
        assign up_valid[gi] = in_valid;
        assign up_data[gi]  = in_data;
      end else begin : g_up_chain
        assign up_valid[gi] = main_valid[gi-1];
        assign up_data[gi]  = main_data[gi-1];
      end

      // Downstream readiness is the next slot's registered skid-empty flag,
      // so ready never ripples combinationally through the chain.
      if (gi == STAGES - 1) begin : g_dn_last
        assign down_ready[gi] = out_ready & !freeze;
      end else begin : g_dn_chain
        assign down_ready[gi] = !skid_valid[gi+1] & !freeze;
      end

      assign accept = up_valid[gi] & !skid_valid_reg & !freeze;
      assign drain  = main_valid_reg & down_ready[gi];

      always_ff @(posedge clk) begin
        if (!rst) begin
          main_valid_reg <= 1'b0;
          skid_valid_reg <= 1'b0;
          main_data_reg  <= '0;
          skid_data_reg  <= '0;
        end else if (flush) begin
          main_valid_reg <= 1'b0;
          skid_valid_reg <= 1'b0;
        end else if (skid_valid_reg) begin
          // Slot is full and not accepting; skid refills main first to keep order.
          if (drain) begin
            main_data_reg  <= skid_data_reg;
            skid_valid_reg <= 1'b0;
          end
        end else if (accept) begin
          if (!main_valid_reg || drain) begin
            main_data_reg  <= up_data[gi];
            main_valid_reg <= 1'b1;
          end else begin
            skid_data_reg  <= up_data[gi];
            skid_valid_reg <= 1'b1;
          end
        end else if (drain) begin
          main_valid_reg <= 1'b0;
        end
      end

      assign main_valid[gi] = main_valid_reg;
      assign skid_valid[gi] = skid_valid_reg;
      assign main_data[gi]  = main_data_reg;
    end
  endgenerate

  // rst gating keeps the handshake quiet for the whole reset window.
  assign in_ready  = !skid_valid[0] & !freeze & rst;
  assign out_valid = main_valid[STAGES-1] & rst;

  assign head_data = main_data[STAGES-1];
  assign {head_wb_en, Mem_R_en, ALU_result, Mem_read_value, Dest} = head_data;
  assign WB_en     = head_wb_en & out_valid;
  assign WB_value  = Mem_R_en ? Mem_read_value : ALU_result;

`ifdef MEM_WB_PERF_CNT_EN
  logic [15:0] stall_cnt_reg;
  logic [15:0] flush_cnt_reg;
  logic        any_valid;

  // A skid entry implies a main entry, but checking both is cheap and robust.
  assign any_valid = |{main_valid, skid_valid};

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (out_valid && !out_ready && !freeze && stall_cnt_reg != 16'hFFFF)
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      if (flush && any_valid && flush_cnt_reg != 16'hFFFF)
        flush_cnt_reg <= flush_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule
